// File: rtl/cam_req_sequencer.sv
// Request sequencer in front of the 8 x 4-bit CAM: buffers lookup-and-replace requests and issues them one at a time.
// Latency: a request pushed into an empty FIFO while idle reaches RESP (rsp_valid high) two edges after the push edge, i.e. in the third cycle.
// Backpressure: req_ready drops when the FIFO is full or the sequencer is re-initialising; a stalled response blocks further issue.

// Small generic synchronous FIFO with extra-MSB pointers for full/empty detection.
// Latency: the head is visible on pop_dat the cycle after the push edge (no bypass).
// Backpressure: the caller must not push when full nor pop when empty; push and pop may coincide.
module cam_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Pointers only; they wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// Sequencer top: FIFO -> issue register -> CAM, then one response per request with hit/miss statistics.
// Latency: pop, one ISSUE cycle, then RESP; back-to-back rate is one request per two cycles.
// Backpressure: RESP holds until rsp_ready; soft_init during ISSUE waits for RESP, where the response is dropped.
module cam_req_sequencer #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             soft_init,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_key,
    input  logic [WIDTH-1:0] req_data,
    output logic             cam_init,
    output logic             cam_en,
    output logic [WIDTH-1:0] cam_lookup,
    output logic [WIDTH-1:0] cam_newd,
    input  logic             cam_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic [WIDTH-1:0] rsp_key,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               init_pend;   // soft_init seen during ISSUE, honoured in RESP
    logic               init_req;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;
    logic               rsp_acc;

    cam_req_fifo #(
        .W     (2*WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat ({req_key, req_data}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign init_req  = soft_init || init_pend;
    assign req_ready = !fifo_full && (state != ST_INIT);
    assign fifo_push = req_valid && req_ready;
    assign cam_init  = (state == ST_INIT);
    assign cam_en    = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_acc   = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    // Next state and FIFO pop; a pending init wins over accepting or issuing.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            ST_INIT: state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (init_req) begin
                    state_nxt = ST_INIT;
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_RESP;
            ST_RESP: begin
                if (init_req) begin
                    state_nxt = ST_INIT;
                end else if (rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ST_ISSUE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Remember a soft_init that arrives while the CAM access is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   init_pend <= 1'b0;
        else if (state_nxt == ST_INIT)  init_pend <= 1'b0;
        else if (soft_init && state == ST_ISSUE) init_pend <= 1'b1;
    end

    // Issue register doubles as the CAM key/data drivers; it holds between pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cam_lookup <= '0;
            cam_newd   <= '0;
        end else if (fifo_pop) begin
            {cam_lookup, cam_newd} <= fifo_head;
        end
    end

    // Capture the CAM match flag at the closing edge of ISSUE, together with the key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_hit <= 1'b0;
            rsp_key <= '0;
        end else if (state == ST_ISSUE) begin
            rsp_hit <= cam_valid;
            rsp_key <= cam_lookup;
        end
    end

    // Saturating statistics, counted on response acceptance and cleared on entry to INIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_nxt == ST_INIT) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rsp_acc) begin
            if (rsp_hit && hit_count != '1)
                hit_count <= hit_count + CNT_W'(1);
            if (!rsp_hit && miss_count != '1)
                miss_count <= miss_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cam_req_sequencer.sv
// Directed bench for cam_req_sequencer with a behavioural 8 x 4-bit CAM attached.
// Expected responses come from a reference CAM evaluated at push time and are queued in a scoreboard.
// A negedge monitor pops the scoreboard on every accepted response.
module tb_cam_req_sequencer;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             soft_init;
    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_key;
    logic [W-1:0]     req_data;
    logic             cam_init;
    logic             cam_en;
    logic [W-1:0]     cam_lookup;
    logic [W-1:0]     cam_newd;
    logic             cam_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [W-1:0]     rsp_key;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] key;
        logic [W-1:0] data;
        logic         hit;
    } exp_t;
    exp_t sb[$];

    // CAM contents after init: entry i = init_tab[4*i +: 4] -> B,7,6,5,4,3,2,1
    logic [31:0] init_tab = 32'h1234_567B;
    logic [W-1:0] cam_mem [8];
    logic [W-1:0] ref_mem [8];
    int           hit_idx;

    cam_req_sequencer #(
        .WIDTH      (W),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .soft_init  (soft_init),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .req_data   (req_data),
        .cam_init   (cam_init),
        .cam_en     (cam_en),
        .cam_lookup (cam_lookup),
        .cam_newd   (cam_newd),
        .cam_valid  (cam_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hit    (rsp_hit),
        .rsp_key    (rsp_key),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CAM: combinational match, replace of first matching entry on the clock edge.
    always_comb begin
        cam_valid = 1'b0;
        hit_idx   = 0;
        for (int i = 7; i >= 0; i--) begin
            if (cam_mem[i] == cam_lookup) begin
                cam_valid = 1'b1;
                hit_idx   = i;
            end
        end
    end

    always @(posedge clk) begin
        if (cam_init) begin
            for (int i = 0; i < 8; i++) cam_mem[i] <= init_tab[4*i +: 4];
        end else if (cam_en && cam_valid) begin
            cam_mem[hit_idx] <= cam_newd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_reload();
        for (int i = 0; i < 8; i++) ref_mem[i] = init_tab[4*i +: 4];
    endfunction

    function automatic logic ref_apply(input logic [W-1:0] k, input logic [W-1:0] d);
        for (int i = 0; i < 8; i++) begin
            if (ref_mem[i] == k) begin
                ref_mem[i] = d;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] pack_cam();
        logic [31:0] v = '0;
        for (int i = 0; i < 8; i++) v[4*i +: 4] = cam_mem[i];
        return v;
    endfunction

    function automatic void sb_add(input logic [W-1:0] k, input logic [W-1:0] d);
        exp_t e;
        e.key  = k;
        e.data = d;
        e.hit  = ref_apply(k, d);
        sb.push_back(e);
    endfunction

    task automatic push(input logic [W-1:0] k, input logic [W-1:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_key   = k;
        req_data  = d;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("push_timeout", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb_add(k, d);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Response monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_key", 32'(rsp_key), 32'(e.key));
                check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] bp_key  [6];
    logic [W-1:0] bp_data [6];
    logic [31:0]  snap;
    int           acc;
    int           n;
    logic         rdy;
    logic         seen;

    initial begin
        reset_n = 1'b0; soft_init = 1'b0; req_valid = 1'b0;
        req_key = '0; req_data = '0; rsp_ready = 1'b0;
        ref_reload();
        bp_key  = '{4'b0001, 4'b1001, 4'b1100, 4'b0011, 4'b1110, 4'b0110};
        bp_data = '{4'b1001, 4'b1010, 4'b0000, 4'b0011, 4'b0001, 4'b0110};

        // Reset values
        #2;
        check("rst_cam_init",  32'(cam_init),   32'd1);
        check("rst_cam_en",    32'(cam_en),     32'd0);
        check("rst_lookup",    32'(cam_lookup), 32'd0);
        check("rst_newd",      32'(cam_newd),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        check("rst_rsp_hit",   32'(rsp_hit),    32'd0);
        check("rst_rsp_key",   32'(rsp_key),    32'd0);
        check("rst_hits",      32'(hit_count),  32'd0);
        check("rst_misses",    32'(miss_count), 32'd0);
        check("rst_req_ready", 32'(req_ready),  32'd0);

        // Release: INIT for exactly one cycle, then ready
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("init_cam_init",  32'(cam_init),  32'd1);
        check("init_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("idle_cam_init",  32'(cam_init),  32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Single hit with cycle-exact latency
        rsp_ready = 1'b1;
        push(4'b1011, 4'b1111);
        @(negedge clk);
        check("lat_pop_cam_en",    32'(cam_en),    32'd0);
        check("lat_pop_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_issue_cam_en",  32'(cam_en),     32'd1);
        check("lat_issue_lookup",  32'(cam_lookup), 32'hB);
        check("lat_issue_newd",    32'(cam_newd),   32'hF);
        check("lat_issue_rsp_vld", 32'(rsp_valid),  32'd0);
        @(negedge clk);
        check("lat_resp_valid", 32'(rsp_valid), 32'd1);
        check("lat_resp_hit",   32'(rsp_hit),   32'd1);
        check("lat_resp_key",   32'(rsp_key),   32'hB);
        @(negedge clk);
        check("hit1_count",    32'(hit_count), 32'd1);
        check("hit1_cam_en",   32'(cam_en),    32'd0);
        check("hold_lookup",   32'(cam_lookup), 32'hB);

        // Replaced value now hits
        push(4'b1111, 4'b1000);
        drain(20);
        check("hit2_count", 32'(hit_count), 32'd2);

        // Miss leaves the CAM untouched
        snap = pack_cam();
        push(4'b0000, 4'b0101);
        drain(20);
        check("miss_count1",   32'(miss_count), 32'd1);
        check("miss_cam_same", pack_cam(),      snap);

        // Backpressure: 4 queued + 1 in flight, then ready drops
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (acc < 6);
            req_key   = bp_key[acc % 6];
            req_data  = bp_data[acc % 6];
            rdy       = req_ready;
            @(posedge clk); #1;
            if (rdy && acc < 6) begin
                sb_add(bp_key[acc], bp_data[acc]);
                acc++;
            end
        end
        req_valid = 1'b0;
        check("bp_accepted",  32'(acc),       32'd5);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_key",   32'(rsp_key),   32'h1);
        @(negedge clk); @(negedge clk);
        check("bp_hold_key",  32'(rsp_key),   32'h1);
        check("bp_hold_vld",  32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        push(bp_key[5], bp_data[5]);
        drain(60);
        check("bp_hits",   32'(hit_count),  32'd6);
        check("bp_misses", 32'(miss_count), 32'd3);

        // soft_init during RESP with two queued requests
        rsp_ready = 1'b0;
        push(4'b0000, 4'b1010);
        push(4'b0010, 4'b1101);
        push(4'b0100, 4'b1110);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("si_resp_reached", 32'(rsp_valid), 32'd1);
        check("si_resp_key",     32'(rsp_key),   32'h0);
        soft_init = 1'b1;
        @(posedge clk); #1;
        soft_init = 1'b0;
        void'(sb.pop_front());
        @(negedge clk);
        check("si_cam_init",  32'(cam_init),   32'd1);
        check("si_rsp_drop",  32'(rsp_valid),  32'd0);
        check("si_hits_clr",  32'(hit_count),  32'd0);
        check("si_miss_clr",  32'(miss_count), 32'd0);
        @(negedge clk);
        check("si_init_once", 32'(cam_init),   32'd0);
        ref_reload();
        for (int i = 0; i < sb.size(); i++) sb[i].hit = ref_apply(sb[i].key, sb[i].data);
        rsp_ready = 1'b1;
        drain(40);
        check("si_hits",   32'(hit_count),  32'd2);
        check("si_misses", 32'(miss_count), 32'd0);

        // Saturation: 260 more hits
        for (int i = 0; i < 260; i++) push(4'b1011, 4'b1011);
        drain(2000);
        check("sat_hits",   32'(hit_count),  32'd255);
        check("sat_misses", 32'(miss_count), 32'd0);

        // Asynchronous reset in the middle of ISSUE, one request still queued
        push(4'b0011, 4'b0010);
        push(4'b0101, 4'b0101);
        n = 0;
        @(negedge clk);
        while (!cam_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ar_in_issue", 32'(cam_en), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("ar_cam_init",  32'(cam_init),   32'd1);
        check("ar_cam_en",    32'(cam_en),     32'd0);
        check("ar_lookup",    32'(cam_lookup), 32'd0);
        check("ar_newd",      32'(cam_newd),   32'd0);
        check("ar_rsp_valid", 32'(rsp_valid),  32'd0);
        check("ar_rsp_hit",   32'(rsp_hit),    32'd0);
        check("ar_rsp_key",   32'(rsp_key),    32'd0);
        check("ar_hits",      32'(hit_count),  32'd0);
        check("ar_misses",    32'(miss_count), 32'd0);
        check("ar_req_ready", 32'(req_ready),  32'd0);
        sb.delete();
        ref_reload();
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || cam_en) seen = 1'b1;
        end
        check("ar_fifo_cleared", 32'(seen),      32'd0);
        check("ar_ready_again",  32'(req_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cam_req_sequencer.md
Name: cam_req_sequencer

Overview:
- Upstream request stage for the 8-entry x 4-bit CAM register file.
- Accepts lookup-and-replace requests over a valid/ready handshake and buffers them in a small FIFO.
- Issues them one at a time to the CAM's init/lookup/newD/valid interface.
- Returns a hit/miss response per request and keeps saturating hit/miss statistics.

Parameters:
- WIDTH, 4, key/data width; must match the CAM entry width.
- FIFO_DEPTH, 4, request buffer depth; power of two, at least 2.
- CNT_W, 8, width of the hit/miss statistic counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- soft_init  in  1  one-cycle pulse; requests CAM re-initialisation.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; high when FIFO not full and FSM not in INIT.
- req_key  in  WIDTH  value to look up.
- req_data  in  WIDTH  replacement value written on a hit.
- cam_init  out  1  drives the CAM init input.
- cam_en  out  1  marks a valid CAM lookup/replace cycle.
- cam_lookup  out  WIDTH  drives the CAM lookup key.
- cam_newd  out  WIDTH  drives the CAM new data.
- cam_valid  in  1  CAM match flag; combinational from cam_lookup against current contents.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_hit  out  1  1 = key was found and replaced.
- rsp_key  out  WIDTH  key of the responded request.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO emptied; FSM in INIT.
  - cam_init=1; cam_en=0; cam_lookup=0; cam_newd=0.
  - rsp_valid=0; rsp_hit=0; rsp_key=0; counters=0; req_ready=0.
- FSM states: INIT, IDLE, ISSUE, RESP.
- INIT:
  - cam_init=1 for exactly one clock after reset deassertion, then go to IDLE.
  - soft_init sampled in IDLE or RESP enters INIT.
  - From RESP, a pending response is dropped (rsp_valid goes 0).
  - Counters are cleared on INIT.
- IDLE:
  - If the FIFO is non-empty, pop the head into the issue register and go to ISSUE the next cycle.
- ISSUE (exactly one cycle):
  - cam_en=1; cam_lookup and cam_newd driven from the issue register.
  - cam_valid is sampled at the closing edge and latched into rsp_hit.
  - The CAM performs the replace on that same edge.
  - Next state is RESP.
- RESP:
  - rsp_valid=1; rsp_hit and rsp_key held stable until rsp_valid && rsp_ready.
  - Then go to IDLE, or directly pop the next request and go to ISSUE if the FIFO is non-empty.
  - Back-to-back throughput is therefore one request per 2 cycles with rsp_ready tied high.
- Counters:
  - Increment on response acceptance, not on lookup.
  - Saturate at 2^CNT_W-1 with no wrap.
- FIFO:
  - Push on req_valid && req_ready.
  - Simultaneous push and pop when full is not allowed: req_ready is low when full.
  - Simultaneous push and pop when non-full keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly FIFO.
- Latency: a request pushed into an empty FIFO in IDLE shows rsp_valid 3 cycles after the push edge (pop, issue, resp).
- soft_init while in ISSUE is deferred until RESP is reached.
- The FIFO contents survive soft_init; only reset_n clears the FIFO.
- cam_lookup and cam_newd hold their last values outside ISSUE. cam_en is the only qualifier.

Test Plan:
- Reset and init: release reset_n -> cam_init high exactly 1 cycle; req_ready rises the next cycle; rsp_valid=0, counters=0.
- Single hit: CAM preloaded with key 4'b1011; send key=4'b1011, data=4'b1111 -> one ISSUE cycle with cam_lookup=1011, cam_newd=1111; rsp_hit=1, rsp_key=1011, hit_count=1. Then send key=1111 -> hit.
- Miss: send key=4'b0000 not present -> rsp_hit=0, miss_count=1, CAM contents unchanged.
- FIFO full/backpressure: hold rsp_ready=0 and push 6 requests -> req_ready low after FIFO_DEPTH+1 accepted (4 queued + 1 in flight); release rsp_ready -> responses return in push order; no loss or duplication.
- soft_init: pulse during RESP with 2 queued requests -> response dropped, cam_init 1 cycle, counters 0; queued requests then processed.
- Saturation and async reset: force 260 hits -> hit_count stays 255. Assert reset_n mid-ISSUE -> all outputs take reset values immediately, without waiting for clk.
